// File: rtl/aes_arbiter.sv
// Two-requester round-robin front end for a single AES core: grants a block,
// launches the core, waits for done with a timeout, and returns the result.
//
// state  | meaning
// IDLE   | waiting for a request; grants one requester in the same cycle
// LAUNCH | aes_start pulse to the core
// CLEAR  | one cycle that ignores the stale done level and clears the timer
// BUSY   | waiting for aes_done or timeout
// RESP   | holding the result until resp_ready
module aes_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [127:0] req0_data,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [127:0] req1_data,
    output logic         req1_ready,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [127:0] resp_data,
    output logic         resp_id,
    output logic         resp_err,
    output logic         aes_rst,
    output logic         aes_start,
    output logic [127:0] aes_state_init,
    input  logic         aes_done,
    input  logic [127:0] aes_state_final,
    output logic         busy
);

    localparam int CW = $clog2(TIMEOUT);
    // Timer value in the last BUSY cycle: its increment would reach TIMEOUT-1.
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 2);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        CLEAR  = 3'd2,
        BUSY   = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic           last_grant_q, last_grant_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [127:0]   init_q, init_d;
    logic [127:0]   rdata_q, rdata_d;
    logic           rid_q, rid_d;
    logic           rerr_q, rerr_d;
    logic           arst_q, arst_d;
    logic           gnt0, gnt1;
    logic           timeout_hit;

    // A handshake that reset would immediately discard is never offered.
    assign gnt0 = rst & req0_valid & (~req1_valid | last_grant_q);
    assign gnt1 = rst & req1_valid & (~req0_valid | ~last_grant_q);
    assign timeout_hit = (cnt_q == TO_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt0 | gnt1) state_d = LAUNCH;
            LAUNCH:  state_d = CLEAR;
            CLEAR:   state_d = BUSY;
            BUSY:    if (aes_done | timeout_hit) state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = (state_q == IDLE) & gnt0;
        req1_ready = (state_q == IDLE) & gnt1;
        aes_start  = (state_q == LAUNCH);
        resp_valid = (state_q == RESP);
        busy       = (state_q != IDLE);
    end

    always_comb begin
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        init_d       = init_q;
        rdata_d      = rdata_q;
        rid_d        = rid_q;
        rerr_d       = rerr_q;
        arst_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt0 | gnt1) begin
                    init_d       = gnt1 ? req1_data : req0_data;
                    rid_d        = gnt1;
                    last_grant_d = gnt1;
                end
            end
            CLEAR: cnt_d = '0;
            BUSY: begin
                cnt_d = cnt_q + CW'(1);
                // done takes priority over a coincident timeout
                if (aes_done) begin
                    rdata_d = aes_state_final;
                    rerr_d  = 1'b0;
                end else if (timeout_hit) begin
                    rdata_d = '0;
                    rerr_d  = 1'b1;
                    arst_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            init_q       <= '0;
            rdata_q      <= '0;
            rid_q        <= 1'b0;
            rerr_q       <= 1'b0;
            arst_q       <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            init_q       <= init_d;
            rdata_q      <= rdata_d;
            rid_q        <= rid_d;
            rerr_q       <= rerr_d;
            arst_q       <= arst_d;
        end
    end

    assign aes_state_init = init_q;
    assign resp_data      = rdata_q;
    assign resp_id        = rid_q;
    assign resp_err       = rerr_q;
    assign aes_rst        = arst_q;

endmodule

// File: tb/tb_aes_arbiter.sv
// Bench for aes_arbiter: directed scenarios, a stand-in AES core, and a
// timestamp-based transaction model compared against the DUT every cycle.
module tb_aes_arbiter;

    localparam int TO = 16;
    localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic [127:0] req0_data = '0, req1_data = '0;
    logic         req0_ready, req1_ready;
    logic         resp_valid, resp_id, resp_err;
    logic         resp_ready = 1'b1;
    logic [127:0] resp_data;
    logic         aes_rst, aes_start, busy;
    logic [127:0] aes_state_init;
    logic         aes_done;
    logic [127:0] aes_state_final;

    logic         core_manual = 1'b0;
    logic         man_done = 1'b0, core_done = 1'b0;
    logic [127:0] man_final = '0, core_final = '0;
    int           core_lat = 5;

    assign aes_done        = core_manual ? man_done  : core_done;
    assign aes_state_final = core_manual ? man_final : core_final;

    int n_chk = 0, n_fail = 0;
    int start_cnt = 0, arst_cnt = 0, r0_cnt = 0, r1_cnt = 0, resp_cnt = 0;
    logic         gl[$];
    logic         rid_log[$];
    logic [127:0] rdat_log[$];

    aes_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_id(resp_id), .resp_err(resp_err),
        .aes_rst(aes_rst), .aes_start(aes_start), .aes_state_init(aes_state_init),
        .aes_done(aes_done), .aes_state_final(aes_state_final), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] enc(input logic [127:0] x);
        if (x == FIPS_PT) return FIPS_CT;
        return {x[63:0], x[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rv(input int maxc, output int n);
        n = 0;
        while (!resp_valid && n < maxc) begin
            tick();
            n++;
        end
        chk("resp_arrived", resp_valid, 1'b1);
    endtask

    // Stand-in core: done level drops on start or aes_rst, rises core_lat cycles after start.
    initial begin : core
        logic s_start, s_rst;
        logic [127:0] s_init, res;
        int rem;
        rem = 0;
        res = '0;
        forever begin
            @(negedge clk);
            s_start = aes_start;
            s_rst   = aes_rst;
            s_init  = aes_state_init;
            @(posedge clk);
            #1;
            if (s_rst === 1'b1) begin
                core_done = 1'b0;
                rem = 0;
            end else if (s_start === 1'b1) begin
                core_done = 1'b0;
                res = enc(s_init);
                rem = core_lat - 1;
                if (rem == 0) begin
                    core_done = 1'b1;
                    core_final = res;
                end
            end else if (rem > 0) begin
                rem--;
                if (rem == 0) begin
                    core_done = 1'b1;
                    core_final = res;
                end
            end
        end
    end

    // Transaction model: a grant at cycle g implies start at g+1, done honoured
    // from g+3, and a timeout decision at g+2+TO-1 (response TO cycles after CLEAR).
    initial begin : monitor
        logic m_ok, m_active, m_resp, m_lg, m_id, m_err, m_arst;
        logic [127:0] m_init, m_data;
        logic e_r0, e_r1;
        int cyc, m_g;
        m_ok = 0; m_active = 0; m_resp = 0; m_lg = 1; m_id = 0; m_err = 0; m_arst = 1;
        m_init = '0; m_data = '0; cyc = 0; m_g = 0;
        forever begin
            @(negedge clk);
            e_r0 = rst && !m_active && req0_valid && (!req1_valid || m_lg);
            e_r1 = rst && !m_active && req1_valid && (!req0_valid || !m_lg);
            if (m_ok) begin
                chk("m_req0_ready", req0_ready, e_r0);
                chk("m_req1_ready", req1_ready, e_r1);
                chk("m_aes_start", aes_start, m_active && (cyc == m_g + 1));
                chk("m_busy", busy, m_active);
                chk("m_resp_valid", resp_valid, m_resp);
                chk("m_aes_rst", aes_rst, m_arst);
                chk("m_aes_state_init", aes_state_init, m_init);
                chk("m_resp_data", resp_data, m_data);
                chk("m_resp_id", resp_id, m_id);
                chk("m_resp_err", resp_err, m_err);
                if (aes_start) start_cnt++;
                if (aes_rst) arst_cnt++;
                if (req0_ready) r0_cnt++;
                if (req1_ready) r1_cnt++;
                if (req0_ready || req1_ready) gl.push_back(req1_ready);
                if (resp_valid && resp_ready) begin
                    rid_log.push_back(resp_id);
                    rdat_log.push_back(resp_data);
                    resp_cnt++;
                end
            end
            if (!rst) begin
                m_ok = 1; m_active = 0; m_resp = 0; m_lg = 1; m_init = '0;
                m_id = 0; m_data = '0; m_err = 0; m_arst = 1;
            end else if (m_ok) begin
                m_arst = 0;
                if (!m_active) begin
                    if (e_r0 || e_r1) begin
                        m_active = 1; m_g = cyc; m_id = e_r1; m_lg = e_r1;
                        m_init = e_r1 ? req1_data : req0_data;
                    end
                end else if (m_resp) begin
                    if (resp_ready) begin
                        m_active = 0; m_resp = 0;
                    end
                end else if (cyc >= m_g + 3) begin
                    if (aes_done) begin
                        m_resp = 1; m_data = aes_state_final; m_err = 0;
                    end else if (cyc == m_g + 2 + TO - 1) begin
                        m_resp = 1; m_data = '0; m_err = 1; m_arst = 1;
                    end
                end
            end
            cyc++;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n, g, t, a0, s0, sr0, sr1, rc0;
        logic [127:0] snap;
        logic exp_ord [4];
        exp_ord = '{1'b0, 1'b1, 1'b0, 1'b1};

        // Reset values, with a request present that must not be acknowledged.
        req0_valid = 1'b1;
        req0_data  = 128'h1;
        tick(); tick(); tick();
        chk("rst_aes_rst", aes_rst, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_req0_ready", req0_ready, 1'b0);
        chk("rst_aes_start", aes_start, 1'b0);
        chk("rst_init", aes_state_init, 128'h0);
        chk("rst_resp_data", resp_data, 128'h0);
        chk("rst_resp_err", resp_err, 1'b0);
        req0_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("rst_release_aes_rst", aes_rst, 1'b0);

        // Single FIPS-197 block, core latency 5.
        core_lat = 5;
        s0 = start_cnt; sr0 = r0_cnt;
        req0_valid = 1'b1;
        req0_data  = FIPS_PT;
        #1;
        chk("single_grant", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        chk("single_start", aes_start, 1'b1);
        wait_rv(60, n);
        chk("single_latency", 32'(n + 1), 32'd7);
        chk("single_data", resp_data, FIPS_CT);
        chk("single_id", resp_id, 1'b0);
        chk("single_err", resp_err, 1'b0);
        tick(); tick();
        chk("single_start_pulses", 32'(start_cnt - s0), 32'd1);
        chk("single_ready_pulses", 32'(r0_cnt - sr0), 32'd1);

        // Contention after reset, minimum core latency.
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        core_lat = 2;
        gl.delete(); rid_log.delete(); rdat_log.delete();
        rc0 = resp_cnt;
        req0_data = 128'haaaa0000aaaa0000aaaa0000aaaa0000;
        req1_data = 128'hbbbb1111bbbb1111bbbb1111bbbb1111;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        g = 0; t = 0;
        while (g < 4 && t < 200) begin
            if (req0_ready || req1_ready) g++;
            tick();
            t++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("cont_grants", 32'(g), 32'd4);
        t = 0;
        while (resp_cnt - rc0 < 4 && t < 100) begin
            tick();
            t++;
        end
        chk("cont_responses", 32'(resp_cnt - rc0), 32'd4);
        if (gl.size() >= 4 && rid_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("cont_order%0d", i), gl[i], exp_ord[i]);
                chk($sformatf("cont_id%0d", i), rid_log[i], exp_ord[i]);
                chk($sformatf("cont_data%0d", i), rdat_log[i],
                    enc(exp_ord[i] ? req1_data : req0_data));
            end
        end

        // Backpressure: result held for 20 cycles with both requesters waiting.
        core_lat = 3;
        resp_ready = 1'b0;
        req0_data = 128'hc0c0c0c0c0c0c0c0c0c0c0c0c0c0c0c0;
        req1_data = 128'hd1d1d1d1d1d1d1d1d1d1d1d1d1d1d1d1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        wait_rv(60, n);
        snap = resp_data;
        chk("bp_data_value", snap, enc(req0_data));
        chk("bp_id", resp_id, 1'b0);
        s0 = start_cnt; sr0 = r0_cnt; sr1 = r1_cnt;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("bp_data_stable", resp_data, snap);
        end
        chk("bp_no_start", 32'(start_cnt - s0), 32'd0);
        chk("bp_no_ready", 32'(r0_cnt - sr0 + r1_cnt - sr1), 32'd0);
        chk("bp_still_valid", resp_valid, 1'b1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b1;
        tick();
        chk("bp_idle_busy", busy, 1'b0);
        chk("bp_idle_rv", resp_valid, 1'b0);

        // Timeout with done tied low.
        core_manual = 1'b1;
        man_done = 1'b0;
        a0 = arst_cnt;
        req1_valid = 1'b1;
        req1_data = 128'he5e5e5e5e5e5e5e5e5e5e5e5e5e5e5e5;
        #1;
        chk("to_grant", req1_ready, 1'b1);
        tick();
        req1_valid = 1'b0;
        wait_rv(40, n);
        chk("to_latency", 32'(n + 1), 32'd18);
        chk("to_err", resp_err, 1'b1);
        chk("to_data", resp_data, 128'h0);
        chk("to_id", resp_id, 1'b1);
        tick(); tick();
        chk("to_arst_pulses", 32'(arst_cnt - a0), 32'd1);

        // done arrives in the very cycle the timeout would fire.
        a0 = arst_cnt;
        man_final = 128'hf00df00df00df00df00df00df00df00d;
        req0_valid = 1'b1;
        req0_data = 128'h0123;
        #1;
        tick();
        req0_valid = 1'b0;
        for (int i = 1; i < 17; i++) tick();
        man_done = 1'b1;
        tick();
        chk("tie_rv", resp_valid, 1'b1);
        chk("tie_err", resp_err, 1'b0);
        chk("tie_data", resp_data, 128'hf00df00df00df00df00df00df00df00d);
        man_done = 1'b0;
        tick(); tick();
        chk("tie_no_arst", 32'(arst_cnt - a0), 32'd0);

        // Stale done level through LAUNCH and CLEAR.
        man_done = 1'b1;
        man_final = 128'h5a5a;
        req1_valid = 1'b1;
        req1_data = 128'h7777;
        #1;
        tick();
        req1_valid = 1'b0;
        tick();
        tick();
        man_done = 1'b0;
        chk("stale_clear_ignored", resp_valid, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stale_wait", resp_valid, 1'b0);
        end
        man_done = 1'b1;
        man_final = 128'h600d600d;
        tick();
        chk("stale_rv", resp_valid, 1'b1);
        chk("stale_data", resp_data, 128'h600d600d);
        man_done = 1'b0;
        tick(); tick();

        // Reset in the middle of BUSY with req0 still pending.
        req0_valid = 1'b1;
        req0_data = 128'h9999888877776666;
        #1;
        for (int i = 0; i < 5; i++) tick();
        chk("mr_in_busy", busy, 1'b1);
        rst = 1'b0;
        tick();
        chk("mr_busy", busy, 1'b0);
        chk("mr_aes_rst", aes_rst, 1'b1);
        chk("mr_rv", resp_valid, 1'b0);
        chk("mr_ready_gated", req0_ready, 1'b0);
        rst = 1'b1;
        core_manual = 1'b0;
        core_lat = 3;
        #1;
        chk("mr_regrant", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        chk("mr_arst_release", aes_rst, 1'b0);
        chk("mr_start", aes_start, 1'b1);
        wait_rv(40, n);
        chk("mr_data", resp_data, enc(128'h9999888877776666));
        chk("mr_err", resp_err, 1'b0);
        tick(); tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
